// File: rtl/e203_exu_alu_dpath_pipe.sv
// e203_exu_alu_dpath_pipe: round-robin arbitration of NCH requesters onto one shared
// adder/shifter/logic datapath, with a registered, backpressured response slot and a
// bank of shared scratch registers.
// Optional: define E203_ALU_DPATH_PIPE2_EN to insert an operand register stage ahead
// of the result stage (latency 2, throughput unchanged).
module e203_exu_alu_dpath_pipe #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NCH  = 3,
    parameter int unsigned CHW  = 2,
    parameter int unsigned TAGW = 4,
    parameter int unsigned NSBF = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  logic [NCH*4-1:0]         req_op,
    input  logic [NCH*XLEN-1:0]      req_op1,
    input  logic [NCH*XLEN-1:0]      req_op2,
    input  logic [NCH*TAGW-1:0]      req_tag,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [CHW-1:0]           rsp_ch,
    output logic [TAGW-1:0]          rsp_tag,
    output logic [XLEN-1:0]          rsp_res,
    output logic                     rsp_cmp,
    input  logic [NSBF-1:0]          sbf_wen,
    input  logic [NSBF*(XLEN+1)-1:0] sbf_wdat,
    output logic [NSBF*(XLEN+1)-1:0] sbf_rdat
);

    localparam int unsigned SHW = $clog2(XLEN);

    localparam logic [3:0] OpAdd  = 4'd0,  OpSub  = 4'd1,  OpAnd  = 4'd2,  OpOr   = 4'd3;
    localparam logic [3:0] OpXor  = 4'd4,  OpSll  = 4'd5,  OpSrl  = 4'd6,  OpSra  = 4'd7;
    localparam logic [3:0] OpSlt  = 4'd8,  OpSltu = 4'd9,  OpMvop2 = 4'd10, OpMax = 4'd11;
    localparam logic [3:0] OpMin  = 4'd12, OpMaxu = 4'd13, OpMinu = 4'd14, OpCmp  = 4'd15;

    logic [CHW-1:0]           ptr_q, ptr_nxt, gnt_idx;
    logic                     any_req, slot_free, accept, load_out;
    logic                     rsp_valid_q, rsp_cmp_q;
    logic [CHW-1:0]           rsp_ch_q;
    logic [TAGW-1:0]          rsp_tag_q;
    logic [XLEN-1:0]          rsp_res_q;
    logic [3:0]               sel_op, alu_op;
    logic [XLEN-1:0]          sel_op1, sel_op2, alu_a, alu_b;
    logic [TAGW-1:0]          sel_tag, alu_tag;
    logic [CHW-1:0]           alu_ch;
    logic [XLEN-1:0]          alu_res, add_res, sh_in, sh_out, sh_res;
    logic                     alu_cmp, cmp_uns, lt, sh_left, sh_inv;
    logic [XLEN:0]            diff;
    logic [SHW-1:0]           shamt;
    logic [NSBF*(XLEN+1)-1:0] sbf_q;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < XLEN; i++) r[i] = v[XLEN-1-i];
        return r;
    endfunction

    // Round-robin search: first valid channel at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        any_req = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (32'(ptr_q) + k) % NCH;
            if (!any_req && req_valid[idx]) begin
                any_req = 1'b1;
                gnt_idx = CHW'(idx);
            end
        end
    end

    assign ptr_nxt = (gnt_idx == CHW'(NCH - 1)) ? '0 : gnt_idx + 1'b1;
    assign accept  = slot_free & ~flush & ~rst & any_req;
    assign sel_op  = req_op[gnt_idx*4 +: 4];
    assign sel_op1 = req_op1[gnt_idx*XLEN +: XLEN];
    assign sel_op2 = req_op2[gnt_idx*XLEN +: XLEN];
    assign sel_tag = req_tag[gnt_idx*TAGW +: TAGW];

    // One-hot grant, only when the request is actually taken this cycle.
    always_comb begin
        req_ready = '0;
        if (accept) req_ready[gnt_idx] = 1'b1;
    end

`ifdef E203_ALU_DPATH_PIPE2_EN
    logic            s1_valid_q, s2_free;
    logic [3:0]      s1_op_q;
    logic [XLEN-1:0] s1_op1_q, s1_op2_q;
    logic [TAGW-1:0] s1_tag_q;
    logic [CHW-1:0]  s1_ch_q;

    assign s2_free   = ~rsp_valid_q | rsp_ready;
    assign slot_free = ~s1_valid_q | s2_free;
    assign load_out  = s1_valid_q & s2_free & ~flush;
    assign alu_op    = s1_op_q;
    assign alu_a     = s1_op1_q;
    assign alu_b     = s1_op2_q;
    assign alu_tag   = s1_tag_q;
    assign alu_ch    = s1_ch_q;

    // Operand stage: captures the arbitrated request, drains into the result stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_op1_q   <= '0;
            s1_op2_q   <= '0;
            s1_tag_q   <= '0;
            s1_ch_q    <= '0;
        end else if (flush) begin
            s1_valid_q <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= sel_op;
            s1_op1_q   <= sel_op1;
            s1_op2_q   <= sel_op2;
            s1_tag_q   <= sel_tag;
            s1_ch_q    <= gnt_idx;
        end else if (s2_free) begin
            s1_valid_q <= 1'b0;
        end
    end
`else
    assign slot_free = ~rsp_valid_q | rsp_ready;
    assign load_out  = accept;
    assign alu_op    = sel_op;
    assign alu_a     = sel_op1;
    assign alu_b     = sel_op2;
    assign alu_tag   = sel_tag;
    assign alu_ch    = gnt_idx;
`endif

    // Shared adder, XLEN+1 comparator and single left shifter (right shifts via bit reversal;
    // negative SRA is computed as ~srl(~a) so the shifter only ever fills with zeros).
    always_comb begin
        add_res = alu_a + alu_b;
        cmp_uns = (alu_op == OpSltu) || (alu_op == OpMaxu) || (alu_op == OpMinu);
        diff    = {~cmp_uns & alu_a[XLEN-1], alu_a} - {~cmp_uns & alu_b[XLEN-1], alu_b};
        lt      = diff[XLEN];
        shamt   = alu_b[SHW-1:0];
        sh_left = (alu_op == OpSll);
        sh_inv  = (alu_op == OpSra) && alu_a[XLEN-1];
        sh_in   = sh_left ? alu_a : bit_rev(sh_inv ? ~alu_a : alu_a);
        sh_out  = sh_in << shamt;
        sh_res  = sh_left ? sh_out : (sh_inv ? ~bit_rev(sh_out) : bit_rev(sh_out));
    end

    // Result and compare-outcome select.
    always_comb begin
        alu_res = '0;
        alu_cmp = 1'b0;
        case (alu_op)
            OpAdd:   alu_res = add_res;
            OpSub:   alu_res = diff[XLEN-1:0];
            OpAnd:   alu_res = alu_a & alu_b;
            OpOr:    alu_res = alu_a | alu_b;
            OpXor:   alu_res = alu_a ^ alu_b;
            OpSll, OpSrl, OpSra: alu_res = sh_res;
            OpSlt, OpSltu: begin
                alu_res = {{(XLEN-1){1'b0}}, lt};
                alu_cmp = lt;
            end
            OpMvop2: alu_res = alu_b;
            OpMax, OpMaxu: alu_res = lt ? alu_b : alu_a;
            OpMin, OpMinu: alu_res = lt ? alu_a : alu_b;
            OpCmp: begin
                alu_res = add_res;
                alu_cmp = (alu_a == alu_b);
            end
            default: alu_res = '0;
        endcase
    end

    // Response slot: flush wins over load and drain; fields hold while not loading.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_ch_q    <= '0;
            rsp_tag_q   <= '0;
            rsp_res_q   <= '0;
            rsp_cmp_q   <= 1'b0;
        end else if (flush) begin
            rsp_valid_q <= 1'b0;
        end else if (load_out) begin
            rsp_valid_q <= 1'b1;
            rsp_ch_q    <= alu_ch;
            rsp_tag_q   <= alu_tag;
            rsp_res_q   <= alu_res;
            rsp_cmp_q   <= alu_cmp;
        end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Round-robin pointer advances past the channel just accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else if (accept) ptr_q <= ptr_nxt;
    end

    // Scratch bank: independent per-register write enables, untouched by flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbf_q <= '0;
        end else begin
            for (int k = 0; k < NSBF; k++) begin
                if (sbf_wen[k]) sbf_q[k*(XLEN+1) +: XLEN+1] <= sbf_wdat[k*(XLEN+1) +: XLEN+1];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_ch    = rsp_ch_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_res   = rsp_res_q;
    assign rsp_cmp   = rsp_cmp_q;
    assign sbf_rdat  = sbf_q;

endmodule
